// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// slave: arbiter side; master: requesters plus memory model.
interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int AW         = 10
);
   logic                  req_0;
   logic                  req_1;
   logic                  we_0;
   logic                  we_1;
   logic [AW-1:0]         addr_0;
   logic [AW-1:0]         addr_1;
   logic [DATA_WIDTH-1:0] wdata_0;
   logic [DATA_WIDTH-1:0] wdata_1;
   logic                  gnt_0;
   logic                  gnt_1;
   logic                  rvalid_0;
   logic                  rvalid_1;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic [AW-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_write;
   logic                  mem_read;
   logic [DATA_WIDTH-1:0] mem_dout;

   modport slave (
      input  req_0, req_1, we_0, we_1,
      input  addr_0, addr_1, wdata_0, wdata_1,
      input  mem_dout,
      output gnt_0, gnt_1, rvalid_0, rvalid_1,
      output rdata, busy,
      output mem_addr, mem_write_data,
      output mem_write, mem_read
   );

   modport master (
      output req_0, req_1, we_0, we_1,
      output addr_0, addr_1, wdata_0, wdata_1,
      output mem_dout,
      input  gnt_0, gnt_1, rvalid_0, rvalid_1,
      input  rdata, busy,
      input  mem_addr, mem_write_data,
      input  mem_write, mem_read
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory.
// One access at a time: IDLE -> ISSUE (-> RESP for reads) -> IDLE.
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input logic           clk,
   input logic           RESET,
   dmem_arbiter_if.slave bus
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  last_owner_q;
   logic                  we_q;
   logic [AW-1:0]         addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  cap;
   logic                  win;

   // Winner: sole requester, else the one that did not win last time.
   assign win = (bus.req_0 & bus.req_1) ? ~last_owner_q : bus.req_1;

   // State register; reset drops any access in flight.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the winning command; owner doubles as last winner.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         last_owner_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else if (cap) begin
         last_owner_q <= win;
         we_q         <= win ? bus.we_1    : bus.we_0;
         addr_q       <= win ? bus.addr_1  : bus.addr_0;
         wdata_q      <= win ? bus.wdata_1 : bus.wdata_0;
      end
   end

   // Next state and state-decoded outputs.
   always_comb begin
      state_d            = state_q;
      cap                = 1'b0;
      bus.gnt_0          = 1'b0;
      bus.gnt_1          = 1'b0;
      bus.rvalid_0       = 1'b0;
      bus.rvalid_1       = 1'b0;
      bus.rdata          = '0;
      bus.busy           = (state_q != IDLE);
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      bus.mem_write      = 1'b0;
      bus.mem_read       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_0 | bus.req_1) begin
               cap     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            bus.gnt_0          = ~last_owner_q;
            bus.gnt_1          = last_owner_q;
            bus.mem_addr       = addr_q;
            bus.mem_write_data = wdata_q;
            bus.mem_write      = we_q;
            bus.mem_read       = ~we_q;
            state_d            = we_q ? IDLE : RESP;
         end
         RESP: begin
            bus.rvalid_0 = ~last_owner_q;
            bus.rvalid_1 = last_owner_q;
            bus.rdata    = bus.mem_dout;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model.
// Table of per-cycle vectors plus hand sequences for multi-cycle cases.
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 10;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   dmem_arbiter_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

   dmem_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(1024)) dut (
      .clk   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:1023];

   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_write_data;
      if (bus.mem_read) bus.mem_dout <= mem[bus.mem_addr];
   end

   typedef struct {
      logic          rst;
      logic          r0;
      logic          w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          r1;
      logic          w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [6:0]    fl;
      logic [AW-1:0] maddr;
      logic [DW-1:0] mwd;
      logic [DW-1:0] rd;
   } vec_t;

   vec_t tv[$];

   function automatic logic [6:0] flags();
      return {bus.gnt_0, bus.gnt_1, bus.rvalid_0, bus.rvalid_1,
              bus.busy, bus.mem_write, bus.mem_read};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic r0, input logic w0,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      rst_n       = rst;
      bus.req_0   = r0;
      bus.we_0    = w0;
      bus.addr_0  = a0;
      bus.wdata_0 = d0;
      bus.req_1   = r1;
      bus.we_1    = w1;
      bus.addr_1  = a1;
      bus.wdata_1 = d1;
   endtask

   task automatic add(input logic rst, input logic r0, input logic w0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [6:0] fl, input logic [AW-1:0] ma,
                      input logic [DW-1:0] mwd, input logic [DW-1:0] rd);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.fl = fl; v.maddr = ma; v.mwd = mwd; v.rd = rd;
      tv.push_back(v);
   endtask

   initial begin
      logic [6:0] exp_fl;
      logic       own;
      n_tests = 0;
      n_fail  = 0;
      bus.mem_dout = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // flags: gnt0 gnt1 rv0 rv1 busy mw mr
      add(0, 0,0,0,0,            0,0,0,0,            7'b0000000, 0, 0, 0);
      add(1, 1,1,5,32'hDEADBEEF, 0,0,0,0,            7'b1000110, 5, 32'hDEADBEEF, 0);
      add(1, 0,0,0,0,            0,0,0,0,            7'b0000000, 0, 0, 0);
      add(1, 0,0,0,0,            1,0,5,0,            7'b0100101, 5, 0, 0);
      add(1, 0,0,0,0,            0,0,0,0,            7'b0001100, 0, 0, 32'hDEADBEEF);
      add(1, 0,0,0,0,            0,0,0,0,            7'b0000000, 0, 0, 0);
      add(1, 1,0,5,0,            0,0,0,0,            7'b1000101, 5, 0, 0);
      add(1, 0,0,0,0,            1,1,9,32'hA5A5A5A5, 7'b0010100, 0, 0, 32'hDEADBEEF);
      add(1, 0,0,0,0,            1,1,9,32'hA5A5A5A5, 7'b0000000, 0, 0, 0);
      add(1, 0,0,0,0,            1,1,9,32'hA5A5A5A5, 7'b0100110, 9, 32'hA5A5A5A5, 0);
      add(1, 0,0,0,0,            0,0,0,0,            7'b0000000, 0, 0, 0);
      add(1, 1,0,5,0,            1,0,9,0,            7'b1000101, 5, 0, 0);
      add(1, 1,0,5,0,            1,0,9,0,            7'b0010100, 0, 0, 32'hDEADBEEF);
      add(1, 1,0,5,0,            1,0,9,0,            7'b0000000, 0, 0, 0);
      add(1, 1,0,5,0,            1,0,9,0,            7'b0100101, 9, 0, 0);
      add(1, 1,0,5,0,            1,0,9,0,            7'b0001100, 0, 0, 32'hA5A5A5A5);
      add(1, 0,0,0,0,            0,0,0,0,            7'b0000000, 0, 0, 0);

      @(negedge clk);
      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0,
               tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d flags", i), 64'(flags()), 64'(tv[i].fl));
         chk($sformatf("v%0d mem_addr", i), 64'(bus.mem_addr), 64'(tv[i].maddr));
         chk($sformatf("v%0d mem_wdata", i), 64'(bus.mem_write_data), 64'(tv[i].mwd));
         chk($sformatf("v%0d rdata", i), 64'(bus.rdata), 64'(tv[i].rd));
         @(negedge clk);
      end

      // Captured address is immune to later input changes.
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("stab issue addr", 64'(bus.mem_addr), 64'd3);
      bus.addr_0 = 9;
      #1;
      chk("stab held addr", 64'(bus.mem_addr), 64'd3);
      chk("stab held rd", 64'(bus.mem_read), 64'd1);
      @(negedge clk);
      drive(1, 0, 0, 9, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("stab resp flags", 64'(flags()), 64'(7'b0010100));
      chk("stab resp rdata", 64'(bus.rdata), 64'd0);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // Reset during a read ISSUE aborts it on the spot.
      drive(1, 1, 0, 7, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("abort pre gnt", 64'(flags()), 64'(7'b1000101));
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort flags", 64'(flags()), 64'd0);
      chk("abort addr", 64'(bus.mem_addr), 64'd0);
      @(posedge clk);
      #1;
      chk("abort no rvalid", 64'(flags()), 64'd0);
      chk("abort rdata", 64'(bus.rdata), 64'd0);
      @(negedge clk);
      drive(1, 1, 0, 5, 0, 1, 0, 9, 0);
      @(posedge clk);
      #1;
      chk("post rst tie", 64'(flags()), 64'(7'b1000101));
      chk("post rst addr", 64'(bus.mem_addr), 64'd5);
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("post rst resp", 64'(flags()), 64'(7'b0010100));
      chk("post rst rdata", 64'(bus.rdata), 64'(32'hDEADBEEF));
      @(negedge clk);

      // Both requesters reading continuously straight out of reset.
      drive(0, 1, 0, 5, 0, 1, 0, 9, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         own = ((k / 3) % 2) == 1;
         exp_fl = 7'b0000000;
         if (k % 3 == 0) exp_fl = own ? 7'b0100101 : 7'b1000101;
         if (k % 3 == 1) exp_fl = own ? 7'b0001100 : 7'b0010100;
         chk($sformatf("rr c%0d flags", k), 64'(flags()), 64'(exp_fl));
         if (k % 3 == 1)
            chk($sformatf("rr c%0d rdata", k), 64'(bus.rdata),
                own ? 64'(32'hA5A5A5A5) : 64'(32'hDEADBEEF));
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, words in data memory; AW = $clog2(MEM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_0, req_1  input  1 each  access request from requester 0 (core load/store) and requester 1 (DMA/debug).
REQ-006 SHALL have ports we_0, we_1  input  1 each  1 = write, 0 = read.
REQ-007 SHALL have ports addr_0, addr_1  input  AW each  word address.
REQ-008 SHALL have ports wdata_0, wdata_1  input  DATA_WIDTH each  write data.
REQ-009 SHALL have ports gnt_0, gnt_1  output  1 each  one-cycle pulse; command accepted.
REQ-010 SHALL have ports rvalid_0, rvalid_1  output  1 each  one-cycle pulse; read data valid.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  shared read-data bus; meaningful only with rvalid_x.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have ports mem_addr (AW), mem_write_data (DATA_WIDTH), mem_write (1), mem_read (1)  output  drive the data memory.
REQ-014 SHALL have port mem_dout  input  DATA_WIDTH  registered read data from the memory; valid the cycle after mem_read.

Function
REQ-015 SHALL implement FSM with states IDLE, ISSUE, RESP.
REQ-016 In IDLE with any req_x high, SHALL select one winner, capture its we/addr/wdata into internal registers, record owner, and go to ISSUE at that edge.
REQ-017 Arbitration: sole requester wins; if both are high, the requester that did not win most recently (last_owner) wins -- round-robin.
REQ-018 In ISSUE, SHALL drive mem_addr/mem_write_data from captured registers, mem_write = captured we, mem_read = !captured we, and gnt_owner = 1, for exactly one cycle.
REQ-019 From ISSUE: write -> IDLE; read -> RESP.
REQ-020 In RESP, SHALL drive rdata = mem_dout and rvalid_owner = 1 for exactly one cycle, then go to IDLE.
REQ-021 Outside ISSUE, mem_write = mem_read = 0, mem_addr = 0, mem_write_data = 0; mem_write and mem_read are never both 1.
REQ-022 Outside RESP, rdata = 0; gnt_x/rvalid_x are never asserted for the non-owner.
REQ-023 Latency: req sampled at edge N -> gnt in cycle N+1 -> rvalid in cycle N+2 (read); write occupies 2 cycles, read 3 cycles, including IDLE.
REQ-024 Requesters hold req/we/addr/wdata stable until gnt; a req still high in the IDLE cycle after gnt is a new request.
REQ-025 Requests arriving in ISSUE or RESP are ignored until the next IDLE; no queueing.
REQ-026 last_owner SHALL update only on entry to ISSUE.
REQ-027 Input changes after capture SHALL NOT affect the access in progress.

Reset
REQ-028 While RESET = 0: state = IDLE, last_owner = 1 (requester 0 wins first tie), captured registers = 0, all outputs = 0.
REQ-029 RESET asserted mid-access SHALL abort it immediately: no gnt or rvalid pulse is issued for the aborted access; mem_write deasserts asynchronously.
REQ-030 After RESET deasserts, the first arbitration occurs at the first rising edge with RESET = 1.

Verification
REQ-031 Single write: req_0 = 1, we_0 = 1, addr_0 = 5, wdata_0 = 0xDEADBEEF -> next cycle gnt_0 = 1, mem_write = 1, mem_addr = 5, mem_write_data = 0xDEADBEEF; following cycle busy = 0.
REQ-032 Read-back: after REQ-031, req_1 = 1, we_1 = 0, addr_1 = 5 -> gnt_1 in cycle N+1, mem_read = 1; rvalid_1 = 1, rdata = 0xDEADBEEF in cycle N+2; rvalid_0 stays 0.
REQ-033 Contention: both req held high continuously from reset, both reads -> grants alternate 0,1,0,1; each requester receives exactly one rvalid per grant.
REQ-034 Late request: req_1 rises during requester 0's ISSUE -> ignored until IDLE, then granted; requester 0 response unaffected.
REQ-035 Reset abort: RESET = 0 during ISSUE of a read to addr 7 -> outputs 0 immediately, no rvalid; after release, req_0 and req_1 tied -> requester 0 granted.
REQ-036 Stability: change addr_0 from 3 to 9 in the ISSUE cycle -> mem_addr remains 3.
